// File: rtl/instr_cache_dm.sv
// Direct-mapped, read-only instruction cache.
// A hit returns the instruction combinationally in the same cycle. A miss
// stalls the core while a two-state FSM refills the whole line one word per
// memory handshake. Saturating hit and miss counters are exported for debug.
module instr_cache_dm #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [31:0]       cpu_instr,
  output logic              cpu_ready,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  typedef enum logic {IDLE, REFILL} stateT;

  stateT             state;
  logic [LINES-1:0]  validBits;
  logic [TAG_W-1:0]  tagMem  [LINES];
  logic [31:0]       dataMem [LINES*WORDS_PER_LINE];

  logic [OFF_W-1:0]  wordCnt;
  logic [IDX_W-1:0]  refillIdx;
  logic [TAG_W-1:0]  refillTag;
  logic              flushPend;
  logic              memReqR;
  logic [ADDR_W-1:0] memAddrR;
  logic [31:0]       hitCnt;
  logic [31:0]       missCnt;

  logic [OFF_W-1:0]  addrOff;
  logic [IDX_W-1:0]  addrIdx;
  logic [TAG_W-1:0]  addrTag;
  logic              lookupHit;
  logic              missStart;
  logic              refillAck;
  logic              lastAck;
  logic              clearAll;
  logic [1:0]        unusedAddrBits;

  // The two byte-offset bits never select anything in a word-wide cache.
  assign unusedAddrBits = cpu_addr[1:0];

  assign addrOff = cpu_addr[2 +: OFF_W];
  assign addrIdx = cpu_addr[2 + OFF_W +: IDX_W];
  assign addrTag = cpu_addr[ADDR_W-1:TAG_LSB];

  // Lookup only happens in IDLE; during a refill the core is always stalled.
  assign lookupHit = (state == IDLE) && cpu_req && validBits[addrIdx]
                     && (tagMem[addrIdx] == addrTag);
  assign missStart = (state == IDLE) && cpu_req && !lookupHit;
  assign refillAck = (state == REFILL) && mem_ack;
  assign lastAck   = refillAck && (wordCnt == OFF_W'(WORDS_PER_LINE - 1));

  // A flush seen in IDLE clears immediately; one seen during a refill (or on
  // its final ack) is deferred so the line is written and then wiped as well.
  assign clearAll  = ((state == IDLE) && flush)
                     || (lastAck && (flushPend || flush));

  assign cpu_ready  = lookupHit;
  assign cpu_instr  = lookupHit ? dataMem[{addrIdx, addrOff}] : 32'h0;
  assign cpu_stall  = cpu_req && !lookupHit;
  assign mem_req    = memReqR;
  assign mem_addr   = memAddrR;
  assign hit_count  = hitCnt;
  assign miss_count = missCnt;

  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : gLine
      logic lineValid;
      // Per-line valid bit: set when this line's refill finishes, cleared by flush.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lineValid <= 1'b0;
        end else if (clearAll) begin
          lineValid <= 1'b0;
        end else if (lastAck && (refillIdx == IDX_W'(gi))) begin
          lineValid <= 1'b1;
        end
      end
      assign validBits[gi] = lineValid;
    end
  endgenerate

  // Data and tag storage are not reset; the valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (refillAck) begin
      dataMem[{refillIdx, wordCnt}] <= mem_rdata;
    end
    if (lastAck) begin
      tagMem[refillIdx] <= refillTag;
    end
  end

  // Refill FSM with registered memory request/address and saturating counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wordCnt   <= '0;
      refillIdx <= '0;
      refillTag <= '0;
      flushPend <= 1'b0;
      memReqR   <= 1'b0;
      memAddrR  <= '0;
      hitCnt    <= '0;
      missCnt   <= '0;
    end else begin
      if (lookupHit && (hitCnt != 32'hFFFF_FFFF)) begin
        hitCnt <= hitCnt + 32'd1;
      end
      case (state)
        IDLE: begin
          if (missStart) begin
            refillIdx <= addrIdx;
            refillTag <= addrTag;
            wordCnt   <= '0;
            memReqR   <= 1'b1;
            memAddrR  <= {cpu_addr[ADDR_W-1:2+OFF_W], {(2+OFF_W){1'b0}}};
            state     <= REFILL;
            if (missCnt != 32'hFFFF_FFFF) begin
              missCnt <= missCnt + 32'd1;
            end
          end
        end
        REFILL: begin
          if (flush) begin
            flushPend <= 1'b1;
          end
          if (mem_ack) begin
            wordCnt  <= wordCnt + 1'b1;
            memAddrR <= memAddrR + ADDR_W'(4);
            if (lastAck) begin
              memReqR   <= 1'b0;
              flushPend <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_cache_dm.sv
// Testbench for instr_cache_dm: directed scenarios followed by a randomized
// phase, every cycle checked against a line-residency reference model with a
// randomly delayed memory responder.
module tb_instr_cache_dm;

  localparam int LINES = 16;
  localparam int WPL   = 4;
  localparam int AW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_instr;
  logic          cpu_ready;
  logic          cpu_stall;
  logic          flush;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;

  always #5 clk = ~clk;

  instr_cache_dm #(.LINES(LINES), .WORDS_PER_LINE(WPL), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_instr(cpu_instr),
    .cpu_ready(cpu_ready), .cpu_stall(cpu_stall), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: which line (address >> 4) each index currently holds,
  // plus an outstanding-refill descriptor.
  bit          resValid [LINES];
  logic [31:0] resLine  [LINES];
  bit          busy;
  bit          pend;
  logic [31:0] base;
  int          got;
  int          expHits;
  int          expMisses;

  // Memory responder knobs
  int waitLeft;
  int maxLat;
  bit idleAckNoise;
  bit sawReady;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ (a >> 3);
  endfunction

  function automatic int lineIdx(input logic [31:0] a);
    return int'((a >> 4) % LINES);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < LINES; k++) resValid[k] = 1'b0;
  endtask

  // One clock cycle: called at a falling edge with cpu_* / flush already set.
  task automatic cycle();
    bit          expReady;
    logic [31:0] expInstr;
    int          i;
    if (mem_req) begin
      if (waitLeft == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = memWord(mem_addr);
      end else begin
        waitLeft--;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      mem_ack   = idleAckNoise && ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
    #1;
    i        = lineIdx(cpu_addr);
    expReady = !busy && cpu_req && resValid[i] && (resLine[i] == (cpu_addr >> 4));
    expInstr = expReady ? memWord(cpu_addr & ~32'h3) : 32'h0;
    chk("cpu_ready", {31'b0, cpu_ready}, {31'b0, expReady});
    chk("cpu_instr", cpu_instr, expInstr);
    chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && !expReady});
    chk("mem_req", {31'b0, mem_req}, {31'b0, busy});
    if (busy) chk("mem_addr", mem_addr, base + 32'(4 * got));
    chk("hit_count", hit_count, 32'(expHits));
    chk("miss_count", miss_count, 32'(expMisses));
    if (!busy) begin
      if (expReady) begin
        expHits++;
        $display("hit   addr=%h instr=%h", cpu_addr, cpu_instr);
      end else if (cpu_req) begin
        expMisses++;
        busy     = 1'b1;
        pend     = 1'b0;
        base     = cpu_addr & ~32'hF;
        got      = 0;
        waitLeft = $urandom_range(0, maxLat);
        $display("miss  addr=%h line=%h", cpu_addr, base);
      end
      if (flush) clearModel();
    end else begin
      if (flush) pend = 1'b1;
      if (mem_ack) begin
        got++;
        waitLeft = $urandom_range(0, maxLat);
        if (got == WPL) begin
          busy = 1'b0;
          if (pend) clearModel();
          else begin
            resValid[lineIdx(base)] = 1'b1;
            resLine[lineIdx(base)]  = base >> 4;
          end
          $display("fill  line=%h flushed=%0d", base, pend);
          pend = 1'b0;
        end
      end
    end
    sawReady = cpu_ready;
    @(negedge clk);
  endtask

  task automatic runUntilReady(input int limit, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!sawReady && n < limit);
    chk("ready_within_bound", {31'b0, sawReady}, 32'd1);
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic asyncReset();
    #3 rst = 1'b0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    clearModel();
    busy = 1'b0; pend = 1'b0; got = 0; expHits = 0; expMisses = 0;
    cpu_req = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    $display("reset asserted");
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    maxLat = 0; idleAckNoise = 1'b0; waitLeft = 0; sawReady = 1'b0;
    clearModel();
    busy = 1'b0; pend = 1'b0; got = 0; base = '0; expHits = 0; expMisses = 0;
    @(negedge clk);
    asyncReset();

    // 1: cold miss at 0x00, ack every cycle
    cpu_req = 1'b1; cpu_addr = 32'h0;
    runUntilReady(20, n);
    chk("t1_ready_cycle", 32'(n), 32'd6);
    chk("t1_miss_count", miss_count, 32'd1);

    // 2: remaining words of the line hit back to back
    for (int a = 4; a <= 12; a += 4) begin
      cpu_addr = 32'(a);
      cycle();
    end
    chk("t2_hit_count", hit_count, 32'd4);

    // 3: conflict on index 0
    cpu_addr = 32'h100;
    runUntilReady(20, n);
    cpu_addr = 32'h0;
    runUntilReady(20, n);
    chk("t3_miss_count", miss_count, 32'd3);

    // 4: flush after the second ack of a refill
    maxLat = 1;
    cpu_addr = 32'h40;
    cycle();
    k = 0;
    while (got < 2 && k < 20) begin
      cycle();
      k++;
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    runUntilReady(40, n);
    chk("t4_miss_count", miss_count, 32'd5);

    // 5: asynchronous reset in the middle of a refill
    cpu_addr = 32'h80;
    cycle();
    cycle();
    asyncReset();
    cpu_req = 1'b1; cpu_addr = 32'h80;
    cycle();
    chk("t5_first_access_miss", {31'b0, mem_req}, 32'd1);
    runUntilReady(40, n);

    // 6: address changes during a refill; captured line finishes first
    cpu_addr = 32'h0;
    cycle();
    cpu_addr = 32'h40;
    runUntilReady(60, n);
    chk("t6_miss_count", miss_count, 32'd3);

    // Randomized phase: small address pool for conflicts and reuse
    maxLat = 3; idleAckNoise = 1'b1;
    for (int c = 0; c < 800; c++) begin
      cpu_req = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 2) == 0)
        cpu_addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2)
                   | 32'($urandom_range(0, 3));
      flush = ($urandom_range(0, 40) == 0);
      cycle();
    end
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
